// File: rtl/matmul_rect_engine.sv
// Rectangular signed matrix-multiply engine: Z = X*Y or Z += X*Y, one Z element per cycle.
// Build option: define MATMUL_SAT_EN to clamp results instead of wrapping.
module matmul_rect_engine #(
    parameter int DATA_WIDTH   = 32,
    parameter int M_WIDTH      = 3,
    parameter int N_WIDTH      = 3,
    parameter int K_SIZE       = 8,
    parameter int Z_ADDR_WIDTH = M_WIDTH + N_WIDTH
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         start,
    input  logic                         acc_mode,
    output logic                         busy,
    output logic                         done,
    output logic [M_WIDTH-1:0]           x_rd_addr,
    input  logic [K_SIZE*DATA_WIDTH-1:0] x_rd_data,
    output logic [N_WIDTH-1:0]           y_rd_addr,
    input  logic [K_SIZE*DATA_WIDTH-1:0] y_rd_data,
    output logic [Z_ADDR_WIDTH-1:0]      z_rd_addr,
    input  logic [DATA_WIDTH-1:0]        z_rd_data,
    output logic                         z_we,
    output logic [Z_ADDR_WIDTH-1:0]      z_wr_addr,
    output logic [DATA_WIDTH-1:0]        z_wr_data
);

    localparam int PROD_WIDTH = 2 * DATA_WIDTH;
    localparam int SUM_WIDTH  = PROD_WIDTH + $clog2(K_SIZE) + 1;
    localparam logic [Z_ADDR_WIDTH-1:0] LAST_ADDR = '1;

    // state   | meaning
    // IDLE    | waiting for start
    // RUN     | issuing one (i, j) address per cycle
    // DRAIN   | pipeline emptying, last writes in flight
    // DONE_ST | one-cycle completion pulse
    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE_ST} state_t;

    state_t state_q, state_d;

    logic [Z_ADDR_WIDTH-1:0] addr_q;
    logic                    acc_q;
    logic                    v1_q, v2_q, we_q;
    logic [Z_ADDR_WIDTH-1:0] a1_q, a2_q, wa_q;
    logic [DATA_WIDTH-1:0]   wdata_q;

    logic signed [PROD_WIDTH-1:0] prod_d [K_SIZE];
    logic signed [PROD_WIDTH-1:0] prod_q [K_SIZE];
    logic [DATA_WIDTH-1:0]        zacc_q;
    logic signed [SUM_WIDTH-1:0]  sum;
    logic [DATA_WIDTH-1:0]        reduced;

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = RUN;
            RUN:     if (addr_q == LAST_ADDR) state_d = DRAIN;
            DRAIN:   if (we_q && (wa_q == LAST_ADDR)) state_d = DONE_ST;
            DONE_ST: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            addr_q  <= '0;
            acc_q   <= 1'b0;
            v1_q    <= 1'b0;
            v2_q    <= 1'b0;
            we_q    <= 1'b0;
            a1_q    <= '0;
            a2_q    <= '0;
            wa_q    <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == IDLE && start) begin
                addr_q <= '0;
                acc_q  <= acc_mode;
            end else if (state_q == RUN) begin
                addr_q <= addr_q + 1'b1;
            end
            // Valid and address travel alongside the data: BRAM read, products, sum.
            v1_q <= (state_q == RUN);
            a1_q <= addr_q;
            v2_q <= v1_q;
            a2_q <= a1_q;
            we_q <= v2_q;
            wa_q <= a2_q;
            if (v2_q) wdata_q <= reduced;
        end
    end

    always_comb begin
        for (int k = 0; k < K_SIZE; k++) begin
            prod_d[k] = {{DATA_WIDTH{x_rd_data[k*DATA_WIDTH + DATA_WIDTH-1]}}, x_rd_data[k*DATA_WIDTH +: DATA_WIDTH]}
                      * {{DATA_WIDTH{y_rd_data[k*DATA_WIDTH + DATA_WIDTH-1]}}, y_rd_data[k*DATA_WIDTH +: DATA_WIDTH]};
        end
    end

    always_ff @(posedge clk) begin
        if (v1_q) begin
            for (int k = 0; k < K_SIZE; k++) prod_q[k] <= prod_d[k];
            zacc_q <= z_rd_data;
        end
    end

    always_comb begin
        sum = '0;
        if (acc_q) sum = {{(SUM_WIDTH-DATA_WIDTH){zacc_q[DATA_WIDTH-1]}}, zacc_q};
        for (int k = 0; k < K_SIZE; k++) begin
            sum = sum + {{(SUM_WIDTH-PROD_WIDTH){prod_q[k][PROD_WIDTH-1]}}, prod_q[k]};
        end
    end

`ifdef MATMUL_SAT_EN
    localparam logic signed [SUM_WIDTH-1:0] SAT_MAX = {{(SUM_WIDTH-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
    localparam logic signed [SUM_WIDTH-1:0] SAT_MIN = {{(SUM_WIDTH-DATA_WIDTH+1){1'b1}}, {(DATA_WIDTH-1){1'b0}}};

    always_comb begin
        reduced = sum[DATA_WIDTH-1:0];
        if (sum > SAT_MAX)      reduced = SAT_MAX[DATA_WIDTH-1:0];
        else if (sum < SAT_MIN) reduced = SAT_MIN[DATA_WIDTH-1:0];
    end
`else
    logic sum_hi_unused;
    assign sum_hi_unused = ^sum[SUM_WIDTH-1:DATA_WIDTH];
    assign reduced       = sum[DATA_WIDTH-1:0];
`endif

    assign busy      = (state_q == RUN) || (state_q == DRAIN);
    assign done      = (state_q == DONE_ST);
    assign x_rd_addr = addr_q[Z_ADDR_WIDTH-1:N_WIDTH];
    assign y_rd_addr = addr_q[N_WIDTH-1:0];
    assign z_rd_addr = addr_q;
    assign z_we      = we_q;
    assign z_wr_addr = wa_q;
    assign z_wr_data = wdata_q;

endmodule
